// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - strobe-driven memory responder with read wait states, sticky error and saturating statistics
// Services one access per strobe assertion; HOLD waits for both strobes low before re-arming.
module mem_responder #(
  parameter int          AWIDTH  = 5,
  parameter int          DWIDTH  = 8,
  parameter int          RD_WAIT = 0,
  parameter logic [15:0] CNT_SAT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              mem_rd,
  input  logic              mem_wr,
  output logic [DWIDTH-1:0] data_out,
  output logic              rd_valid,
  output logic              wr_done,
  output logic              err,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int DEPTH = 2**AWIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]        state;
  logic [3:0]        wait_cnt;
  logic [AWIDTH-1:0] rd_addr;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic              both;
  logic              wr_go;

  assign both  = mem_rd & mem_wr;
  assign wr_go = rst_ & (state == IDLE) & mem_wr & ~mem_rd;

  // The array is deliberately left out of reset so contents survive rst_.
  always_ff @(posedge clk) begin
    if (wr_go) mem[addr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      rd_addr  <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
      err      <= 1'b0;
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else begin
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
      if (both) err <= 1'b1;
      case (state)
        IDLE: begin
          if (mem_rd && !mem_wr) begin
            rd_addr  <= addr;
            wait_cnt <= 4'(RD_WAIT);
            state    <= READ;
          end else if (mem_wr && !mem_rd) begin
            wr_done <= 1'b1;
            if (wr_count != CNT_SAT) wr_count <= wr_count + 16'd1;
            state   <= HOLD;
          end else if (both) begin
            state <= HOLD;
          end
        end
        READ: begin
          // A write strobe here is a violation; the pending read still completes.
          if (mem_wr) err <= 1'b1;
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            data_out <= mem[rd_addr];
            rd_valid <= 1'b1;
            if (rd_count != CNT_SAT) rd_count <= rd_count + 16'd1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (!mem_rd && !mem_wr) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
